button_event_generator: RTL

- Consumes the clean level from the button debouncer and converts it into single-cycle event pulses for the seven-segment display controller.
- Produces press, release, long-press and auto-repeat events.
- Repeat events let a held button step a displayed digit/value at a fixed rate.
- One instance per debounced button. Input is already synchronous to clock.

---
 rtl/button_event_generator_pkg.sv | 20 ++
 rtl/button_event_generator_interval.sv | 23 ++
 rtl/button_event_generator.sv | 105 ++++++++++
 3 files changed

// File: rtl/button_event_generator_pkg.sv
// Shared state encoding, default timing constants and parameter-range helper
// for the button event generator and its debouncer neighbours.
package button_event_generator_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE      = 2'd0,
    STATE_PRESSED   = 2'd1,
    STATE_REPEATING = 2'd2
  } state_t;

  // 100 MHz defaults: 0.5 s long press, 0.1 s repeat period.
  localparam int unsigned DEFAULT_COUNTER_WIDTH     = 26;
  localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 50_000_000;
  localparam int unsigned DEFAULT_REPEAT_CYCLES     = 10_000_000;

  function automatic bit cycles_fit(input int unsigned cycles, input int unsigned width);
    return (cycles >= 2) && (64'(cycles) <= ((64'(1) << width) - 64'(1)));
  endfunction

endpackage

// File: rtl/button_event_generator_interval.sv
// Clearable up-counter with a terminal-count compare against a supplied target.
module interval_counter #(
  parameter int unsigned WIDTH = 26
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] target,
  output logic             terminal
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign terminal = (count == target);

endmodule

// File: rtl/button_event_generator.sv
// Turns a debounced button level into press/release/long-press/auto-repeat
// single-cycle pulses plus a held level. The release/repeat pulses are named
// release_event/repeat_event because release and repeat are reserved words.
module button_event_generator
  import button_event_generator_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH     = DEFAULT_COUNTER_WIDTH,
  parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter int unsigned REPEAT_CYCLES     = DEFAULT_REPEAT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic press,
  output logic release_event,
  output logic long_press,
  output logic repeat_event,
  output logic held
);

  if (!cycles_fit(LONG_PRESS_CYCLES, COUNTER_WIDTH) || !cycles_fit(REPEAT_CYCLES, COUNTER_WIDTH))
  begin : g_bad_params
    $error("button_event_generator: cycle parameters out of range for COUNTER_WIDTH");
  end

  localparam logic [COUNTER_WIDTH-1:0] LONG_TARGET   = COUNTER_WIDTH'(LONG_PRESS_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] REPEAT_TARGET = COUNTER_WIDTH'(REPEAT_CYCLES - 1);

  state_t                   state;
  logic                     in_d;
  logic                     active;
  logic                     terminal;
  logic                     clear;
  logic                     enable;
  logic [COUNTER_WIDTH-1:0] target;

  // Counter sits at zero in IDLE and restarts at each threshold hit or release.
  assign active = (state != STATE_IDLE);
  assign target = (state == STATE_PRESSED) ? LONG_TARGET : REPEAT_TARGET;
  assign clear  = !active || !in || terminal;
  assign enable = active && in && !terminal;

  interval_counter #(.WIDTH(COUNTER_WIDTH)) u_interval (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .enable   (enable),
    .target   (target),
    .terminal (terminal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= STATE_IDLE;
      in_d          <= 1'b0;
      press         <= 1'b0;
      release_event <= 1'b0;
      long_press    <= 1'b0;
      repeat_event  <= 1'b0;
      held          <= 1'b0;
    end else begin
      in_d          <= in;
      press         <= 1'b0;
      release_event <= 1'b0;
      long_press    <= 1'b0;
      repeat_event  <= 1'b0;
      case (state)
        STATE_IDLE: begin
          held <= 1'b0;
          if (in && !in_d) begin
            press        <= 1'b1;
            repeat_event <= 1'b1;
            state        <= STATE_PRESSED;
          end
        end
        STATE_PRESSED: begin
          if (!in) begin
            release_event <= 1'b1;
            state         <= STATE_IDLE;
          end else if (terminal) begin
            long_press   <= 1'b1;
            repeat_event <= 1'b1;
            state        <= STATE_REPEATING;
          end
        end
        STATE_REPEATING: begin
          // Release wins over a coincident repeat threshold.
          if (!in) begin
            release_event <= 1'b1;
            held          <= 1'b0;
            state         <= STATE_IDLE;
          end else begin
            held <= 1'b1;
            if (terminal) repeat_event <= 1'b1;
          end
        end
        default: begin
          held  <= 1'b0;
          state <= STATE_IDLE;
        end
      endcase
    end
  end

endmodule
